// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared types and helpers for the multi-channel UART
//                transmitter. Provides the per-channel state encoding, the
//                baud divisor calculation, counter width helpers and the
//                configuration legality check used at elaboration.
//                The optional parity stage is enabled by UART_TX_MULTI_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

    // Per-channel frame state. ST_PARITY is only reachable when
    // UART_TX_MULTI_PARITY_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Clock cycles per bit. A zero baud rate yields 0 so the configuration
    // check flags it instead of dividing by zero.
    function automatic int calc_div(input int clock_rate, input int baud_rate);
        return (baud_rate > 0) ? (clock_rate / baud_rate) : 0;
    endfunction

    // Width of a counter that runs 0..count-1; never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction

    // Legal configuration space of the transmitter.
    function automatic bit cfg_ok(input int div, input int num_ch,
                                  input int data_bits, input int stop_bits,
                                  input int parity_odd);
        return (div >= 1) &&
               (num_ch >= 1) && (num_ch <= 8) &&
               (data_bits >= 5) && (data_bits <= 8) &&
               ((stop_bits == 1) || (stop_bits == 2)) &&
               ((parity_odd == 0) || (parity_odd == 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Free-running 0..DIV-1 counter producing a one-cycle tick
//                when the count equals DIV-1. The first tick therefore
//                arrives DIV cycles after reset release. With DIV = 1 the
//                tick is permanently high.
//  Ports       : clk   - system clock
//                reset - asynchronous active-high reset
//                tick  - single-cycle bit-time strobe
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            C_CW   = cnt_width(DIV);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(DIV - 1);

    logic [C_CW-1:0] cnt_q;
    logic [C_CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == C_LAST) ? '0 : (cnt_q + C_CW'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_multi.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_multi
//  Description : NUM_CH independent UART transmitters sharing one baud tick.
//                Each channel has a valid/ready input with a one-entry
//                holding buffer so frames can run back-to-back.
//                Frame: start(0), DATA_BITS data LSB first, optional parity,
//                STOP_BITS stop bits (1).
//                Optional feature macro: UART_TX_MULTI_PARITY_EN inserts a
//                parity bit (even, or odd when PARITY_ODD = 1).
//  Ports       : clk      - system clock
//                reset    - asynchronous active-high reset
//                tx_data  - per-channel byte, channel i at [i*DATA_BITS +: DATA_BITS]
//                tx_valid - per-channel byte valid
//                tx_ready - per-channel holding buffer empty
//                tx_pin   - per-channel serial line, idle high, registered
//                busy     - channel framing a byte or holding one
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_multi
    import uart_tx_pkg::*;
#(
    parameter int CLOCK_RATE = 1000,
    parameter int BAUD_RATE  = 100,
    parameter int NUM_CH     = 2,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH*DATA_BITS-1:0]   tx_data,
    input  logic [NUM_CH-1:0]             tx_valid,
    output logic [NUM_CH-1:0]             tx_ready,
    output logic [NUM_CH-1:0]             tx_pin,
    output logic [NUM_CH-1:0]             busy
);

    localparam int C_DIV = calc_div(CLOCK_RATE, BAUD_RATE);
    localparam int C_BCW = $clog2(DATA_BITS + 1);

    generate
        if (!cfg_ok(C_DIV, NUM_CH, DATA_BITS, STOP_BITS, PARITY_ODD)) begin : g_cfg_err
            $error("uart_tx_multi: illegal configuration (DIV, NUM_CH, DATA_BITS, STOP_BITS or PARITY_ODD)");
        end
    endgenerate

    logic w_tick;

    uart_baud_gen #(
        .DIV (C_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            tx_state_t              state_q, state_d;
            logic [DATA_BITS-1:0]   shift_q, shift_d;
            logic [DATA_BITS-1:0]   hold_q, hold_d;
            logic                   hold_valid_q, hold_valid_d;
            logic                   pin_q, pin_d;
            logic [C_BCW-1:0]       bit_cnt_q, bit_cnt_d;
            logic                   stop_cnt_q, stop_cnt_d;
            logic                   w_load;
`ifdef UART_TX_MULTI_PARITY_EN
            logic                   parity_q, parity_d;
`endif

            always_comb begin
                state_d      = state_q;
                shift_d      = shift_q;
                hold_d       = hold_q;
                hold_valid_d = hold_valid_q;
                pin_d        = pin_q;
                bit_cnt_d    = bit_cnt_q;
                stop_cnt_d   = stop_cnt_q;
                w_load       = 1'b0;
`ifdef UART_TX_MULTI_PARITY_EN
                parity_d     = parity_q;
`endif

                // Fill the holding buffer; it is only accepted while empty,
                // so this never collides with the load below.
                if (tx_valid[gi] && !hold_valid_q) begin
                    hold_d       = tx_data[gi*DATA_BITS +: DATA_BITS];
                    hold_valid_d = 1'b1;
                end

                if (w_tick) begin
                    case (state_q)
                        ST_IDLE: begin
                            w_load = hold_valid_q;
                        end
                        ST_START: begin
                            pin_d     = shift_q[0];
                            shift_d   = shift_q >> 1;
                            bit_cnt_d = C_BCW'(1);
                            state_d   = ST_DATA;
                        end
                        ST_DATA: begin
                            // bit_cnt counts data bits already placed on the line.
                            if (bit_cnt_q == C_BCW'(DATA_BITS)) begin
`ifdef UART_TX_MULTI_PARITY_EN
                                pin_d   = parity_q;
                                state_d = ST_PARITY;
`else
                                pin_d      = 1'b1;
                                stop_cnt_d = 1'b0;
                                state_d    = ST_STOP;
`endif
                            end else begin
                                pin_d     = shift_q[0];
                                shift_d   = shift_q >> 1;
                                bit_cnt_d = bit_cnt_q + C_BCW'(1);
                            end
                        end
`ifdef UART_TX_MULTI_PARITY_EN
                        ST_PARITY: begin
                            pin_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
`endif
                        ST_STOP: begin
                            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                                // Final stop bit ends: chain straight into the
                                // next frame if one is waiting.
                                w_load  = hold_valid_q;
                                state_d = ST_IDLE;
                                pin_d   = 1'b1;
                            end else begin
                                stop_cnt_d = stop_cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            pin_d   = 1'b1;
                        end
                    endcase

                    if (w_load) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        state_d      = ST_START;
                        pin_d        = 1'b0;
`ifdef UART_TX_MULTI_PARITY_EN
                        parity_d     = (^hold_q) ^ (PARITY_ODD != 0);
`endif
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q      <= ST_IDLE;
                    shift_q      <= '0;
                    hold_q       <= '0;
                    hold_valid_q <= 1'b0;
                    pin_q        <= 1'b1;
                    bit_cnt_q    <= '0;
                    stop_cnt_q   <= 1'b0;
`ifdef UART_TX_MULTI_PARITY_EN
                    parity_q     <= 1'b0;
`endif
                end else begin
                    state_q      <= state_d;
                    shift_q      <= shift_d;
                    hold_q       <= hold_d;
                    hold_valid_q <= hold_valid_d;
                    pin_q        <= pin_d;
                    bit_cnt_q    <= bit_cnt_d;
                    stop_cnt_q   <= stop_cnt_d;
`ifdef UART_TX_MULTI_PARITY_EN
                    parity_q     <= parity_d;
`endif
                end
            end

            assign tx_pin[gi]   = pin_q;
            assign tx_ready[gi] = !hold_valid_q;
            assign busy[gi]     = (state_q != ST_IDLE) | hold_valid_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_multi
//  Description : Self-checking bench for uart_tx_multi. Instance u_dut0 uses
//                the default configuration (DIV=10, 2 channels, 8N1);
//                instance u_dut1 uses DIV=1, 7 data bits, 2 stop bits,
//                PARITY_ODD=1. Expected line waveforms are built from the
//                frame definition (start, data LSB first, optional parity,
//                stop bits) and checked cycle by cycle.
//                Honours UART_TX_MULTI_PARITY_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_multi;

    localparam int DIV0 = 10;
    localparam int NCH  = 2;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic [NCH*8-1:0]   tx_data0  = '0;
    logic [NCH-1:0]     tx_valid0 = '0;
    logic [NCH-1:0]     tx_ready0, tx_pin0, busy0;
    logic [6:0]         tx_data1  = '0;
    logic [0:0]         tx_valid1 = '0;
    logic [0:0]         tx_ready1, tx_pin1, busy1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_multi #(
        .CLOCK_RATE (1000), .BAUD_RATE (100), .NUM_CH (NCH),
        .DATA_BITS  (8),    .STOP_BITS (1),   .PARITY_ODD (0)
    ) u_dut0 (
        .clk (clk), .reset (reset), .tx_data (tx_data0), .tx_valid (tx_valid0),
        .tx_ready (tx_ready0), .tx_pin (tx_pin0), .busy (busy0)
    );

    uart_tx_multi #(
        .CLOCK_RATE (1000), .BAUD_RATE (1000), .NUM_CH (1),
        .DATA_BITS  (7),    .STOP_BITS (2),    .PARITY_ODD (1)
    ) u_dut1 (
        .clk (clk), .reset (reset), .tx_data (tx_data1), .tx_valid (tx_valid1),
        .tx_ready (tx_ready1), .tx_pin (tx_pin1), .busy (busy1)
    );

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic [7:0] exp_ser;   // data bits in line order, first sent in bit 7
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic pin(input int dut, input int ch);
        return (dut == 0) ? tx_pin0[ch] : tx_pin1[0];
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send0(input int ch, input logic [7:0] d);
        int n = 0;
        while (tx_ready0[ch] !== 1'b1 && n < 4*DIV0) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ready_wait ch%0d", ch), 32'(tx_ready0[ch]), 32'd1);
        tx_data0[ch*8 +: 8] = d;
        tx_valid0[ch]       = 1'b1;
        @(negedge clk);
        tx_valid0[ch]       = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d);
        tx_data1     = d[6:0];
        tx_valid1[0] = 1'b1;
        @(negedge clk);
        tx_valid1[0] = 1'b0;
    endtask

    // Waits up to 'budget' negedges for a start bit, then checks every cycle
    // of the whole frame against the reference frame for that instance.
    task automatic expect_frame(input int dut, input int ch, input logic [7:0] data,
                                input int budget, output int waited,
                                output logic [7:0] ser);
        bit   q[$];
        int   div, nb, ns;
        logic podd, seen, found;
        if (dut == 0) begin div = DIV0; nb = 8; ns = 1; podd = 1'b0; end
        else          begin div = 1;    nb = 7; ns = 2; podd = 1'b1; end
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) q.push_back(data[i]);
`ifdef UART_TX_MULTI_PARITY_EN
        begin
            int ones = 0;
            for (int i = 0; i < nb; i++) ones += int'(data[i]);
            q.push_back(((ones % 2) == 1) ^ podd);
        end
`endif
        for (int s = 0; s < ns; s++) q.push_back(1'b1);

        ser    = '0;
        waited = 0;
        found  = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (pin(dut, ch) === 1'b0) begin
                found  = 1'b1;
                waited = i;
                break;
            end
        end
        chk($sformatf("start_seen dut%0d ch%0d", dut, ch), 32'(found), 32'd1);
        if (!found) return;
        for (int b = 0; b < q.size(); b++) begin
            seen = q[b];
            for (int c = 0; c < div; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (pin(dut, ch) !== q[b]) seen = pin(dut, ch);
                if (b >= 1 && b <= nb && c == div/2) ser = {ser[6:0], pin(dut, ch)};
            end
            chk($sformatf("frame dut%0d ch%0d data=%0h bit%0d", dut, ch, data, b),
                32'(seen), 32'(q[b]));
        end
    endtask

    task automatic rand_chan(input int ch, input int n);
        int         gap, w;
        logic [7:0] d, s;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 30);
            repeat (gap) @(negedge clk);
            d = 8'($urandom);
            fork
                send0(ch, d);
                expect_frame(0, ch, d, DIV0 + 3, w, s);
            join
            repeat (1) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[6];
        int         w, w0, w1, n;
        logic [7:0] s, s0, s1;
        logic       ok;

        vecs[0] = '{0, 8'h55, 8'b10101010};
        vecs[1] = '{1, 8'h01, 8'b10000000};
        vecs[2] = '{0, 8'h80, 8'b00000001};
        vecs[3] = '{1, 8'hF0, 8'b00001111};
        vecs[4] = '{0, 8'hA3, 8'b11000101};
        vecs[5] = '{1, 8'h3C, 8'b00111100};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst tx_pin0",   32'(tx_pin0),   32'h3);
        chk("rst tx_ready0", 32'(tx_ready0), 32'h3);
        chk("rst busy0",     32'(busy0),     32'h0);
        chk("rst tx_pin1",   32'(tx_pin1),   32'h1);
        chk("rst busy1",     32'(busy1),     32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single frames from the table, each followed by idle checks
        for (int i = 0; i < 6; i++) begin
            fork
                send0(vecs[i].ch, vecs[i].data);
                expect_frame(0, vecs[i].ch, vecs[i].data, DIV0 + 3, w, s);
            join
            chk($sformatf("ser vec%0d", i), 32'(s), 32'(vecs[i].exp_ser));
            chk($sformatf("busy_in_stop vec%0d", i), 32'(busy0[vecs[i].ch]), 32'd1);
            @(negedge clk);
            chk($sformatf("busy_fall vec%0d", i), 32'(busy0[vecs[i].ch]), 32'd0);
            ok = 1'b1;
            repeat (DIV0) begin
                if (tx_pin0[vecs[i].ch] !== 1'b1) ok = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("idle_high vec%0d", i), 32'(ok), 32'd1);
        end

        // Simultaneous accepts on both channels
        tx_data0  = {8'h3C, 8'hA3};
        tx_valid0 = 2'b11;
        fork
            begin @(negedge clk); tx_valid0 = 2'b00; end
            expect_frame(0, 0, 8'hA3, DIV0 + 3, w0, s0);
            expect_frame(0, 1, 8'h3C, DIV0 + 3, w1, s1);
        join
        chk("simul_start_align", 32'(w0), 32'(w1));
        chk("simul ser ch0", 32'(s0), 32'b11000101);
        chk("simul ser ch1", 32'(s1), 32'b00111100);
        repeat (DIV0 + 2) @(negedge clk);

        // Back-to-back on ch1 with valid held high
        tx_data0[15:8] = 8'h00;
        tx_valid0[1]   = 1'b1;
        fork
            begin
                @(negedge clk);
                tx_data0[15:8] = 8'hFF;
                n = 0;
                while (tx_ready0[1] !== 1'b1 && n < 3*DIV0) begin
                    @(negedge clk);
                    n++;
                end
                chk("b2b ready_rise", 32'(tx_ready0[1]), 32'd1);
                @(negedge clk);
                chk("b2b ready_pulse_width", 32'(tx_ready0[1]), 32'd0);
                tx_valid0[1] = 1'b0;
            end
            begin
                expect_frame(0, 1, 8'h00, DIV0 + 3, w, s);
                expect_frame(0, 1, 8'hFF, 1, w1, s1);
            end
        join
        repeat (2*DIV0) @(negedge clk);

        // Reset during data bit 4, with a second byte waiting in the buffer
        fork
            send0(0, 8'h00);
            begin
                n = 0;
                while (tx_pin0[0] !== 1'b0 && n < 3*DIV0) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        repeat (5*DIV0 + 3) @(negedge clk);
        chk("pre_reset data bit low", 32'(tx_pin0[0]), 32'd0);
        send0(0, 8'h5A);
        chk("pre_reset buffer full", 32'(tx_ready0[0]), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("mid_reset tx_pin0",   32'(tx_pin0),   32'h3);
        chk("mid_reset tx_ready0", 32'(tx_ready0), 32'h3);
        chk("mid_reset busy0",     32'(busy0),     32'h0);
        @(negedge clk);
        reset        = 1'b0;
        tx_data0[7:0] = 8'hC3;
        tx_valid0[0] = 1'b1;
        fork
            begin @(negedge clk); tx_valid0[0] = 1'b0; end
            expect_frame(0, 0, 8'hC3, 3*DIV0, w, s);
        join
        chk("first_tick_after_reset", 32'(w), 32'd10);
        chk("post_reset ser", 32'(s), 32'b11000011);
        repeat (DIV0 + 2) @(negedge clk);

        // DIV=1 instance: 7 data bits, 2 stop bits
        fork
            send1(8'h41);
            expect_frame(1, 0, 8'h41, 4, w, s);
        join
        chk("div1 ser 41", 32'(s[6:0]), 32'h41);
        @(negedge clk);
        chk("div1 busy_fall", 32'(busy1[0]), 32'd0);
        chk("div1 idle pin", 32'(tx_pin1[0]), 32'd1);
        fork
            send1(8'h0B);
            expect_frame(1, 0, 8'h0B, 4, w, s);
        join
        chk("div1 ser 0B", 32'(s[6:0]), 32'h68);
        repeat (3) @(negedge clk);

        // Randomised traffic on both channels in parallel
        fork
            rand_chan(0, 10);
            rand_chan(1, 10);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_multi.md
Name: uart_tx_multi

Overview:
Parametrised multi-channel UART transmitter. It generalises the fixed two-pin message transmitter to NUM_CH independent channels, with a configurable baud rate, data width and stop-bit count. Each channel has a valid/ready byte input with a one-entry holding buffer, so frames can be sent back-to-back. It sits below the tapeout top and drives io_out serial pins, fed by any byte source (message ROM, counter, etc.).

Parameters:
CLOCK_RATE, 1000, input clock frequency in Hz.
BAUD_RATE, 100, line rate in bit/s. DIV = CLOCK_RATE/BAUD_RATE (integer division). DIV < 1 is an elaboration error.
NUM_CH, 2, number of independent TX channels (1..8).
DATA_BITS, 8, data bits per frame (5..8), LSB first.
STOP_BITS, 1, stop bits per frame (1 or 2).
PARITY_ODD, 0, parity sense when UART_TX_MULTI_PARITY_EN is defined: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tx_data  input  NUM_CH*DATA_BITS  per-channel byte; channel i occupies [i*DATA_BITS +: DATA_BITS]
tx_valid  input  NUM_CH  per-channel byte valid
tx_ready  output  NUM_CH  per-channel holding buffer empty
tx_pin  output  NUM_CH  serial line per channel, idle high
busy  output  NUM_CH  channel is framing a byte or holding one

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: tx_pin all 1, tx_ready all 1, busy all 0, baud counter 0, all FSMs IDLE, holding buffers empty.
- Baud tick: one shared free-running counter 0..DIV-1. A single-cycle tick is asserted when the counter equals DIV-1, so the first tick comes DIV cycles after reset release. Every channel advances only on a tick, so each bit lasts exactly DIV cycles.
- Handshake, per channel: tx_ready = !hold_valid. A transfer occurs when tx_valid & tx_ready. The byte is latched and hold_valid = 1 on the next edge. tx_data is don't-care when tx_valid is low.
- FSM states, per channel: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- Load rule: on a tick, if the state is IDLE, or STOP with the final stop bit ending, and hold_valid = 1:
  - shifter <= hold byte, hold_valid <= 0;
  - state <= START, tx_pin <= 0.
  Otherwise STOP ending goes to IDLE and tx_pin stays 1.
- Transitions on each tick:
  - START -> DATA: drive bit0.
  - DATA: shift right and drive the next bit. After DATA_BITS bits, go to PARITY, or to STOP when the macro is undefined.
  - PARITY -> STOP.
  - STOP: hold tx_pin = 1 for STOP_BITS bit-times.
- Timing: the start bit begins on the first tick after hold_valid is registered, so accept-to-start latency is 1..DIV cycles. A byte accepted in the same cycle as a tick waits for the next tick. With the buffer kept full, frames are back-to-back with no idle gap.
- Line output: tx_pin is registered, with no combinational path from the inputs.
- busy[i] = (state != IDLE) | hold_valid.
- Counters: the bit counter is $clog2(DATA_BITS+1) bits wide and the stop counter is 1 bit.
- Channel independence: channels share only the tick. Simultaneous accepts on all channels are legal.
- Reset mid-frame: the line returns to 1 immediately (asynchronously), the frame is lost and the buffer is cleared.

Optional Feature:
UART_TX_MULTI_PARITY_EN
- Defined: a parity bit is inserted after the data bits. The bit is the XOR of the data bits, XOR PARITY_ODD, computed at load time. Frame length = 1 + DATA_BITS + 1 + STOP_BITS bit-times.
- Undefined: there is no PARITY state and no parity logic, and PARITY_ODD is ignored.

Decomposition:
- Package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - localparam function for DIV and counter widths;
  - elaboration checks on DIV, DATA_BITS and STOP_BITS.
- Sub-module uart_baud_gen (parameter DIV; ports clk, reset, tick), instantiated once and shared by all channels.
- The per-channel FSM and holding buffer live in a generate loop in uart_tx_multi.

Test Plan:
- Defaults (DIV=10), send 0x55 on ch0:
  - tx_pin[0] = 0 (start), then 1,0,1,0,1,0,1,0, each exactly 10 cycles;
  - then 1 for at least 10 cycles;
  - busy[0] falls on the cycle after the stop tick.
- Hold tx_valid[1] high with 0x00 then 0xFF: two frames with no idle between the stop bit and the next start bit; tx_ready[1] pulses high once per frame.
- Simultaneous 0xA3 on ch0 and 0x3C on ch1 at the same cycle: both start bits begin on the same tick, and the waveforms decode independently.
- Assert reset during bit 4 of a frame:
  - tx_pin goes to 1 the same cycle;
  - tx_ready = 1 and busy = 0;
  - after release, the first tick is exactly 10 cycles later.
- STOP_BITS=2, DATA_BITS=7, macro defined with PARITY_ODD=1, send 0x41: 7 data bits, then parity 1, then 20 cycles high.
- BAUD_RATE=1000 (DIV=1), send 0x81: every bit lasts 1 cycle and the frame is 10 cycles.
